// File: rtl/anffl_tex_etc2_quad_sequencer.sv
// ============================================================================
// Module   : anffl_tex_etc2_quad_sequencer
// Purpose  : Feeds one 2x2 texel quad through a shared ETC2 block decoder.
//            It issues one texel per cycle and returns the packed RGBA quad.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module anffl_tex_etc2_quad_sequencer #(
  parameter int FORCE_OPAQUE = 1,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_block,
  input  logic [4:0]         in_format,
  input  logic [7:0]         in_u,
  input  logic [7:0]         in_v,
  input  logic [3:0]         in_mask,
  output logic [127:0]       dec_data,
  output logic [4:0]         dec_format,
  output logic [1:0]         dec_u,
  output logic [1:0]         dec_v,
  input  logic [7:0]         dec_r,
  input  logic [7:0]         dec_g,
  input  logic [7:0]         dec_b,
  input  logic [7:0]         dec_a,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_rgba,
  output logic [3:0]         out_mask,
  output logic               busy,
  output logic [CNT_W-1:0]   stat_texels
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_in_ready;
  logic               w_accept;
  logic [2:0]         w_first;
  logic [2:0]         w_next;
  logic [7:0]         w_alpha;

  logic [127:0]       r_block;
  logic [4:0]         r_format;
  logic [7:0]         r_u;
  logic [7:0]         r_v;
  logic [3:0]         r_mask;
  logic [1:0]         r_ptr;
  logic [1:0]         r_dec_u;
  logic [1:0]         r_dec_v;
  logic [127:0]       r_rgba;
  logic [CNT_W-1:0]   r_stat;

  // Returns {found, lane} for the lowest enabled lane.
  function automatic logic [2:0] f_first(input logic [3:0] m);
    f_first = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) f_first = {1'b1, 2'(i)};
    end
  endfunction

  // Returns {found, lane} for the lowest enabled lane above p.
  function automatic logic [2:0] f_after(input logic [3:0] m, input logic [1:0] p);
    f_after = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && (2'(i) > p)) f_after = {1'b1, 2'(i)};
    end
  endfunction

  assign w_first  = f_first(in_mask);
  assign w_next   = f_after(r_mask, r_ptr);
  assign w_accept = in_valid && w_in_ready;
  assign w_alpha  = (FORCE_OPAQUE != 0) ? 8'hFF : dec_a;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Ready in OUT depends on out_ready so a new quad can follow with no bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_nxt = w_first[2] ? S_ISSUE : S_OUT;
      end
      S_ISSUE: begin
        if (!w_next[2]) w_state_nxt = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          w_in_ready  = 1'b1;
          w_state_nxt = in_valid ? (w_first[2] ? S_ISSUE : S_OUT) : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_block  <= '0;
      r_format <= '0;
      r_u      <= '0;
      r_v      <= '0;
      r_mask   <= '0;
      r_ptr    <= '0;
      r_dec_u  <= '0;
      r_dec_v  <= '0;
      r_rgba   <= '0;
      r_stat   <= '0;
    end else if (w_accept) begin
      r_u    <= in_u;
      r_v    <= in_v;
      r_mask <= in_mask;
      r_rgba <= '0;
      // An empty quad leaves the decoder inputs untouched.
      if (w_first[2]) begin
        r_block  <= in_block;
        r_format <= in_format;
        r_ptr    <= w_first[1:0];
        r_dec_u  <= in_u[{w_first[1:0], 1'b0} +: 2];
        r_dec_v  <= in_v[{w_first[1:0], 1'b0} +: 2];
      end
    end else if (r_state == S_ISSUE) begin
      r_rgba[{r_ptr, 5'b00000} +: 32] <= {dec_r, dec_g, dec_b, w_alpha};
      r_stat <= r_stat + CNT_W'(1);
      if (w_next[2]) begin
        r_ptr   <= w_next[1:0];
        r_dec_u <= r_u[{w_next[1:0], 1'b0} +: 2];
        r_dec_v <= r_v[{w_next[1:0], 1'b0} +: 2];
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = (r_state == S_OUT);
  assign busy        = (r_state != S_IDLE);
  assign dec_data    = r_block;
  assign dec_format  = r_format;
  assign dec_u       = r_dec_u;
  assign dec_v       = r_dec_v;
  assign out_rgba    = r_rgba;
  assign out_mask    = r_mask;
  assign stat_texels = r_stat;

endmodule

`default_nettype wire

// File: tb/tb_anffl_tex_etc2_quad_sequencer.sv
// ============================================================================
// Module   : tb_anffl_tex_etc2_quad_sequencer
// Purpose  : Self-checking bench: opaque/16-bit and real-alpha/4-bit instances.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_anffl_tex_etc2_quad_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, out_ready;
  logic [127:0] in_block;
  logic [4:0]   in_format;
  logic [7:0]   in_u, in_v;
  logic [3:0]   in_mask;

  logic         m_in_ready, m_out_valid, m_busy;
  logic [127:0] m_dec_data, m_out_rgba;
  logic [4:0]   m_dec_format;
  logic [1:0]   m_dec_u, m_dec_v;
  logic [7:0]   m_dec_r, m_dec_g, m_dec_b, m_dec_a;
  logic [3:0]   m_out_mask;
  logic [15:0]  m_stat;

  logic         x_in_ready, x_out_valid, x_busy;
  logic [127:0] x_dec_data, x_out_rgba;
  logic [4:0]   x_dec_format;
  logic [1:0]   x_dec_u, x_dec_v;
  logic [7:0]   x_dec_r, x_dec_g, x_dec_b, x_dec_a;
  logic [3:0]   x_out_mask;
  logic [3:0]   x_stat;

  // Decoder stand-in: texel (u,v) selects a 32-bit word, tinted by format.
  function automatic logic [31:0] f_dec(input logic [127:0] d, input logic [4:0] f,
                                        input logic [1:0] u, input logic [1:0] v);
    int idx;
    idx = 2 * int'(v) + int'(u);
    return d[32*idx +: 32] ^ {3'b000, f, 24'h000000};
  endfunction

  assign {m_dec_r, m_dec_g, m_dec_b, m_dec_a} = f_dec(m_dec_data, m_dec_format, m_dec_u, m_dec_v);
  assign {x_dec_r, x_dec_g, x_dec_b, x_dec_a} = f_dec(x_dec_data, x_dec_format, x_dec_u, x_dec_v);

  anffl_tex_etc2_quad_sequencer #(.FORCE_OPAQUE(1), .CNT_W(16)) u_main (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_block(in_block), .in_format(in_format), .in_u(in_u), .in_v(in_v), .in_mask(in_mask),
    .dec_data(m_dec_data), .dec_format(m_dec_format), .dec_u(m_dec_u), .dec_v(m_dec_v),
    .dec_r(m_dec_r), .dec_g(m_dec_g), .dec_b(m_dec_b), .dec_a(m_dec_a),
    .out_valid(m_out_valid), .out_ready(out_ready), .out_rgba(m_out_rgba),
    .out_mask(m_out_mask), .busy(m_busy), .stat_texels(m_stat)
  );

  anffl_tex_etc2_quad_sequencer #(.FORCE_OPAQUE(0), .CNT_W(4)) u_aux (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(x_in_ready),
    .in_block(in_block), .in_format(in_format), .in_u(in_u), .in_v(in_v), .in_mask(in_mask),
    .dec_data(x_dec_data), .dec_format(x_dec_format), .dec_u(x_dec_u), .dec_v(x_dec_v),
    .dec_r(x_dec_r), .dec_g(x_dec_g), .dec_b(x_dec_b), .dec_a(x_dec_a),
    .out_valid(x_out_valid), .out_ready(out_ready), .out_rgba(x_out_rgba),
    .out_mask(x_out_mask), .busy(x_busy), .stat_texels(x_stat)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int unsigned  mdl_stat;
  logic [127:0] cur_block, exp_main, exp_aux, last_data;
  logic [4:0]   cur_fmt, last_fmt;
  logic [7:0]   cur_u, cur_v;
  logic [3:0]   cur_mask;
  logic [1:0]   last_u, last_v;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_inputs();
    in_block  = {$urandom, $urandom, $urandom, $urandom};
    in_format = 5'($urandom);
    in_u      = 8'($urandom);
    in_v      = 8'($urandom);
    in_mask   = 4'($urandom);
  endtask

  task automatic drive_req(input logic [3:0] mask, input logic [7:0] u, input logic [7:0] v);
    logic [31:0] w;
    cur_block = {$urandom, $urandom, $urandom, $urandom};
    cur_fmt   = 5'($urandom);
    cur_u     = u;
    cur_v     = v;
    cur_mask  = mask;
    in_block  = cur_block;
    in_format = cur_fmt;
    in_u      = u;
    in_v      = v;
    in_mask   = mask;
    in_valid  = 1'b1;
    exp_main  = '0;
    exp_aux   = '0;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        w = f_dec(cur_block, cur_fmt, u[2*i +: 2], v[2*i +: 2]);
        exp_main[32*i +: 32] = {w[31:8], 8'hFF};
        exp_aux[32*i +: 32]  = w;
      end
    end
  endtask

  // Called one step after a request is driven; ends in the OUT cycle.
  task automatic accept_and_issue();
    int n;
    out_ready = 1'b1;
    #1;
    chk("in_ready_at_accept", {127'd0, m_in_ready}, 128'd1);
    tick();
    in_valid = 1'b0;
    junk_inputs();
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (cur_mask[i]) begin
        chk("issue_out_valid", {127'd0, m_out_valid}, 128'd0);
        chk("issue_in_ready", {127'd0, m_in_ready}, 128'd0);
        chk("issue_dec_u", {126'd0, m_dec_u}, {126'd0, cur_u[2*i +: 2]});
        chk("issue_dec_v", {126'd0, m_dec_v}, {126'd0, cur_v[2*i +: 2]});
        chk("issue_dec_data", m_dec_data, cur_block);
        chk("issue_dec_format", {123'd0, m_dec_format}, {123'd0, cur_fmt});
        last_u    = cur_u[2*i +: 2];
        last_v    = cur_v[2*i +: 2];
        last_data = cur_block;
        last_fmt  = cur_fmt;
        n++;
        tick();
      end
    end
    mdl_stat += n;
    chk("out_valid", {127'd0, m_out_valid}, 128'd1);
    chk("out_busy", {127'd0, m_busy}, 128'd1);
    chk("out_rgba_opaque", m_out_rgba, exp_main);
    chk("out_rgba_alpha", x_out_rgba, exp_aux);
    chk("out_mask", {124'd0, m_out_mask}, {124'd0, cur_mask});
    chk("stat16", {112'd0, m_stat}, {112'd0, mdl_stat[15:0]});
    chk("stat4", {124'd0, x_stat}, {124'd0, mdl_stat[3:0]});
    chk("dec_hold_u", {126'd0, m_dec_u}, {126'd0, last_u});
    chk("dec_hold_v", {126'd0, m_dec_v}, {126'd0, last_v});
    chk("dec_hold_data", m_dec_data, last_data);
    chk("dec_hold_format", {123'd0, m_dec_format}, {123'd0, last_fmt});
  endtask

  task automatic stall(input int cycles);
    out_ready = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      junk_inputs();
      in_valid = 1'b1;
      #1;
      chk("stall_out_valid", {127'd0, m_out_valid}, 128'd1);
      chk("stall_in_ready", {127'd0, m_in_ready}, 128'd0);
      chk("stall_rgba", m_out_rgba, exp_main);
      chk("stall_rgba_alpha", x_out_rgba, exp_aux);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    #1;
    chk("release_in_ready", {127'd0, m_in_ready}, 128'd1);
    tick();
    chk("idle_out_valid", {127'd0, m_out_valid}, 128'd0);
    chk("idle_busy", {127'd0, m_busy}, 128'd0);
    chk("idle_in_ready", {127'd0, m_in_ready}, 128'd1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"}, {127'd0, m_in_ready}, 128'd1);
    chk({tag, "_out_valid"}, {126'd0, m_out_valid, x_out_valid}, 128'd0);
    chk({tag, "_busy"}, {127'd0, m_busy}, 128'd0);
    chk({tag, "_rgba"}, m_out_rgba, 128'd0);
    chk({tag, "_mask"}, {124'd0, m_out_mask}, 128'd0);
    chk({tag, "_dec_data"}, m_dec_data, 128'd0);
    chk({tag, "_dec_uvf"}, {119'd0, m_dec_format, m_dec_u, m_dec_v}, 128'd0);
    chk({tag, "_stat"}, {108'd0, x_stat, m_stat}, 128'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_block  = '0;
    in_format = '0;
    in_u      = '0;
    in_v      = '0;
    in_mask   = '0;
    mdl_stat  = 0;
    last_u    = '0;
    last_v    = '0;
    last_data = '0;
    last_fmt  = '0;
    repeat (3) tick();
    check_reset_state("reset");
    rst = 1'b0;
    tick();

    // Full quad, lanes (0,0),(1,0),(0,1),(1,1)
    drive_req(4'hF, 8'h44, 8'h50);
    accept_and_issue();
    release_out();

    // Sparse mask
    drive_req(4'b1010, 8'($urandom), 8'($urandom));
    accept_and_issue();
    release_out();

    // Empty mask: straight to OUT, decoder inputs untouched
    drive_req(4'b0000, 8'($urandom), 8'($urandom));
    accept_and_issue();
    release_out();

    // Backpressure then back-to-back acceptance
    drive_req(4'hF, 8'($urandom), 8'($urandom));
    accept_and_issue();
    stall(5);
    drive_req(4'b1100, 8'($urandom), 8'($urandom));
    accept_and_issue();
    release_out();

    // Reset in the middle of a quad
    drive_req(4'hF, 8'($urandom), 8'($urandom));
    #1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check_reset_state("midquad_reset");
    rst       = 1'b0;
    mdl_stat  = 0;
    last_u    = '0;
    last_v    = '0;
    last_data = '0;
    last_fmt  = '0;

    // Counter wrap on the 4-bit instance, then randomized quads
    for (int q = 0; q < 24; q++) begin
      if (q < 5) drive_req(4'hF, 8'($urandom), 8'($urandom));
      else       drive_req(4'($urandom), 8'($urandom), 8'($urandom));
      accept_and_issue();
      if ($urandom_range(0, 1) == 1) stall(int'($urandom_range(1, 3)));
      if (q % 3 == 0) release_out();
    end
    release_out();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

endmodule

`default_nettype wire
